// File: rtl/l2_cache_control_if.sv
// Request, metadata and physical-memory signals between the L2 sequencing FSM
// and the surrounding datapath / upstream arbiter.
interface l2_cache_control_if;
  logic       mem_read, mem_write, mem_resp;
  logic       way0_hit, way1_hit, way2_hit, way3_hit;
  logic       valid0_out, valid1_out, valid2_out, valid3_out;
  logic       dirty0_out, dirty1_out, dirty2_out, dirty3_out;
  logic [1:0] LRU_way_select;
  logic       vc_dirty, pmem_resp;
  logic       pmem_read, pmem_write;
  logic       tag_comp, idling, pmem_addr_sel, dirty_from_vc;
  logic       valid0_in, valid1_in, valid2_in, valid3_in;
  logic       valid0_wr_enable, valid1_wr_enable, valid2_wr_enable, valid3_wr_enable;
  logic       dirty0_in, dirty1_in, dirty2_in, dirty3_in;
  logic       alloc_dirty0_write, alloc_dirty1_write, alloc_dirty2_write, alloc_dirty3_write;

  // Controller side.
  modport master (
    input  mem_read, mem_write, mem_resp,
    input  way0_hit, way1_hit, way2_hit, way3_hit,
    input  valid0_out, valid1_out, valid2_out, valid3_out,
    input  dirty0_out, dirty1_out, dirty2_out, dirty3_out,
    input  LRU_way_select, vc_dirty, pmem_resp,
    output pmem_read, pmem_write, tag_comp, idling, pmem_addr_sel, dirty_from_vc,
    output valid0_in, valid1_in, valid2_in, valid3_in,
    output valid0_wr_enable, valid1_wr_enable, valid2_wr_enable, valid3_wr_enable,
    output dirty0_in, dirty1_in, dirty2_in, dirty3_in,
    output alloc_dirty0_write, alloc_dirty1_write, alloc_dirty2_write, alloc_dirty3_write
  );

  // Datapath / upstream side.
  modport slave (
    output mem_read, mem_write, mem_resp,
    output way0_hit, way1_hit, way2_hit, way3_hit,
    output valid0_out, valid1_out, valid2_out, valid3_out,
    output dirty0_out, dirty1_out, dirty2_out, dirty3_out,
    output LRU_way_select, vc_dirty, pmem_resp,
    input  pmem_read, pmem_write, tag_comp, idling, pmem_addr_sel, dirty_from_vc,
    input  valid0_in, valid1_in, valid2_in, valid3_in,
    input  valid0_wr_enable, valid1_wr_enable, valid2_wr_enable, valid3_wr_enable,
    input  dirty0_in, dirty1_in, dirty2_in, dirty3_in,
    input  alloc_dirty0_write, alloc_dirty1_write, alloc_dirty2_write, alloc_dirty3_write
  );
endinterface

// File: rtl/l2_cache_control.sv
// Sequencing FSM for a 4-way L2 cache: hit/miss decision, dirty-victim writeback,
// line fill, metadata update of the allocated way, and saturating event counters.
module l2_cache_control #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  l2_cache_control_if.master bus,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  typedef enum logic [1:0] {S_IDLE, S_TAG_CHECK, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_victim;
  logic             r_retry, r_drop;
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

  logic [3:0] w_way_hit, w_valid, w_dirty;
  logic       w_req, w_hit, w_victim_dirty;
  logic       w_pmem_read, w_pmem_write, w_tag_comp, w_idling, w_addr_sel, w_dfv;
  logic [3:0] w_valid_we, w_valid_in, w_dirty_in, w_alloc_dw;
  logic       w_cnt_hit, w_cnt_miss, w_cnt_wb;

  assign w_way_hit = {bus.way3_hit, bus.way2_hit, bus.way1_hit, bus.way0_hit};
  assign w_valid   = {bus.valid3_out, bus.valid2_out, bus.valid1_out, bus.valid0_out};
  assign w_dirty   = {bus.dirty3_out, bus.dirty2_out, bus.dirty1_out, bus.dirty0_out};
  assign w_req     = bus.mem_read | bus.mem_write;
  assign w_hit     = (|w_way_hit) | bus.mem_resp;
  // An invalid line is never written back, whatever its dirty bit says.
  assign w_victim_dirty = w_valid[bus.LRU_way_select] & w_dirty[bus.LRU_way_select];

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_next       = r_state;
    w_pmem_read  = 1'b0;
    w_pmem_write = 1'b0;
    w_tag_comp   = 1'b0;
    w_idling     = 1'b0;
    w_addr_sel   = 1'b0;
    w_dfv        = 1'b0;
    w_valid_we   = 4'b0000;
    w_valid_in   = 4'b0000;
    w_dirty_in   = 4'b0000;
    w_alloc_dw   = 4'b0000;
    w_cnt_hit    = 1'b0;
    w_cnt_miss   = 1'b0;
    w_cnt_wb     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idling = 1'b1;
        if (w_req) w_next = S_TAG_CHECK;
      end
      S_TAG_CHECK: begin
        w_tag_comp = 1'b1;
        w_dirty_in = {4{bus.mem_write}};
        if (!w_req) begin
          w_next = S_IDLE;
        end else if (w_hit) begin
          w_next    = S_IDLE;
          w_cnt_hit = ~r_retry;
        end else begin
          w_cnt_miss = 1'b1;
          w_next     = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        w_pmem_write = 1'b1;
        w_addr_sel   = 1'b1;
        if (bus.pmem_resp) begin
          w_cnt_wb = 1'b1;
          w_next   = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        w_pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          w_valid_we = 4'b0001 << r_victim;
          w_valid_in = 4'b0001 << r_victim;
          w_alloc_dw = 4'b0001 << r_victim;
          w_dfv      = bus.vc_dirty;
          w_next     = (r_drop || !w_req) ? S_IDLE : S_TAG_CHECK;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_victim   <= 2'd0;
      r_retry    <= 1'b0;
      r_drop     <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      if (w_cnt_miss) r_victim <= bus.LRU_way_select;
      if (r_state == S_ALLOCATE && bus.pmem_resp)
        r_retry <= (w_next == S_TAG_CHECK);
      else if (r_state == S_TAG_CHECK && w_next == S_IDLE)
        r_retry <= 1'b0;
      // A request abandoned mid-transaction must not re-enter TAG_CHECK.
      if (w_next == S_IDLE)
        r_drop <= 1'b0;
      else if ((r_state == S_WRITEBACK || r_state == S_ALLOCATE) && !w_req)
        r_drop <= 1'b1;
      if (w_cnt_hit)  r_hit_cnt  <= sat_inc(r_hit_cnt);
      if (w_cnt_miss) r_miss_cnt <= sat_inc(r_miss_cnt);
      if (w_cnt_wb)   r_wb_cnt   <= sat_inc(r_wb_cnt);
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
  assign wb_count   = r_wb_cnt;

  assign bus.pmem_read     = w_pmem_read;
  assign bus.pmem_write    = w_pmem_write;
  assign bus.tag_comp      = w_tag_comp;
  assign bus.idling        = w_idling;
  assign bus.pmem_addr_sel = w_addr_sel;
  assign bus.dirty_from_vc = w_dfv;

  assign bus.valid0_in = w_valid_in[0];
  assign bus.valid1_in = w_valid_in[1];
  assign bus.valid2_in = w_valid_in[2];
  assign bus.valid3_in = w_valid_in[3];
  assign bus.valid0_wr_enable = w_valid_we[0];
  assign bus.valid1_wr_enable = w_valid_we[1];
  assign bus.valid2_wr_enable = w_valid_we[2];
  assign bus.valid3_wr_enable = w_valid_we[3];
  assign bus.dirty0_in = w_dirty_in[0];
  assign bus.dirty1_in = w_dirty_in[1];
  assign bus.dirty2_in = w_dirty_in[2];
  assign bus.dirty3_in = w_dirty_in[3];
  assign bus.alloc_dirty0_write = w_alloc_dw[0];
  assign bus.alloc_dirty1_write = w_alloc_dw[1];
  assign bus.alloc_dirty2_write = w_alloc_dw[2];
  assign bus.alloc_dirty3_write = w_alloc_dw[3];

endmodule

// File: doc/l2_cache_control.md
# l2_cache_control

Sequencing FSM for the 4-way, 4-set L2 cache datapath.
- Sits between the L1/arbiter-side request interface and the datapath control pins.
- Decides hit vs. miss, issues dirty-victim writebacks and line fills to physical memory, and writes the valid/dirty metadata for the allocated way.
- Also keeps saturating hit/miss/writeback event counters for performance analysis.

## Interface
Parameters:
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_read, mem_write  in  1 each  upstream request; held stable until mem_resp
- mem_resp  in  1  hit response from datapath hit-select logic
- way0_hit..way3_hit  in  1 each  per-way hit from datapath
- valid0_out..valid3_out, dirty0_out..dirty3_out  in  1 each  metadata of the indexed set
- LRU_way_select  in  2  current replacement way
- vc_dirty  in  1  line being filled carries dirty data from the victim cache
- pmem_resp  in  1  physical-memory completion
- pmem_read, pmem_write  out  1 each  physical-memory command
- tag_comp, idling, pmem_addr_sel, dirty_from_vc  out  1 each  datapath controls
- valid0_in..valid3_in, valid0_wr_enable..valid3_wr_enable  out  1 each
- dirty0_in..dirty3_in, alloc_dirty0_write..alloc_dirty3_write  out  1 each
- hit_count, miss_count, wb_count  out  CNT_W each  event counters

## Operation
States:
- IDLE: idling=1. Go to TAG_CHECK when mem_read|mem_write.
- TAG_CHECK: tag_comp=1. dirtyN_in=mem_write for all N; the datapath gates the write per hit way.
  - Any wayN_hit: go to IDLE. The datapath raises mem_resp this cycle.
  - Miss: latch victim=LRU_way_select.
    - If validN_out&dirtyN_out for N=victim: go to WRITEBACK.
    - Otherwise: go to ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1 (victim tag address). On pmem_resp: wb_count++, go to ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_addr_sel=0.
  - On pmem_resp (same cycle, victim way only): valid_wr_enable=1, valid_in=1, alloc_dirty_write=1, dirty_in=0, dirty_from_vc=vc_dirty.
  - Set the retry flag and go to TAG_CHECK.

Counter rules:
- Victim way is taken from the latched register in WRITEBACK and ALLOCATE, never from live LRU_way_select.
- Counters are evaluated in TAG_CHECK only:
  - hit with retry=0: hit_count++
  - miss: miss_count++
  - hit with retry=1: no count, retry cleared
- Counters saturate at 2^CNT_W-1 and never wrap.

Boundary cases:
- Request dropped during WRITEBACK/ALLOCATE: the pmem transaction still completes, the metadata is still written, then the FSM goes to IDLE instead of TAG_CHECK.
- Request dropped in TAG_CHECK: go to IDLE, no count.
- mem_read and mem_write both high: treated as a write.
- Invalid victim (valid=0) is never written back, regardless of its dirty bit.

## Timing
Reset:
- Asserting reset_n low immediately forces IDLE.
- All outputs go to 0 except idling=1. Counters, victim and retry clear to 0.
- pmem_read and pmem_write drop asynchronously, including mid-transaction.

Output style:
- All control outputs decode combinationally from state, plus pmem_resp/hit inputs where stated above.

Latencies (from request seen in IDLE):
- Hit: mem_resp in the 2nd cycle.
- Clean miss: 1 IDLE + 1 TAG_CHECK + (fill latency) ALLOCATE + 1 TAG_CHECK.
- Dirty miss: adds the WRITEBACK latency.

Handshake rules:
- pmem_read/pmem_write stay high continuously until the cycle pmem_resp=1, and drop the next cycle.
- They are never both high.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- After a completed request the FSM returns to IDLE for at least one cycle, even if a new request is already pending.

## Test plan
- Read hit: preload way2 valid, tag match; mem_read -> TAG_CHECK cycle with tag_comp=1 and mem_resp; hit_count=1, miss_count=0; no pmem activity.
- Clean miss: LRU=1, valid1=0, pmem_resp after 5 cycles -> pmem_read high exactly 5 cycles, valid1_wr_enable/alloc_dirty1_write pulse 1 cycle, retry TAG_CHECK hits; miss_count=1, hit_count=0.
- Dirty miss on write: LRU=3, valid3=dirty3=1 -> pmem_write with pmem_addr_sel=1 until pmem_resp, then pmem_read; wb_count=1; final TAG_CHECK drives dirty3_in=1.
- Victim-cache fill: vc_dirty=1 during an ALLOCATE completion -> dirty_from_vc=1 in the pmem_resp cycle only.
- Reset mid-WRITEBACK: drop reset_n with pmem_write=1 -> pmem_write=0 with no clock edge; idling=1; counters 0.
- Saturation: CNT_W=2, 5 hits -> hit_count stays 3.
